// File: rtl/msf_timekeeper.sv
// Running BCD time-of-day plus MSF sync state machine; qualifies decoded frames against the local clock.
// All outputs are registered with one cycle of latency; no backpressure, and every frame gets one accept or reject pulse.
module msf_timekeeper #(
    parameter int HOLDOVER_MINUTES = 60
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       tick_1hz_i,
    input  logic       frame_valid_i,
    input  logic [1:0] frame_hour_h_i,
    input  logic [3:0] frame_hour_l_i,
    input  logic [2:0] frame_minute_h_i,
    input  logic [3:0] frame_minute_l_i,
    output logic [1:0] hour_h_o,
    output logic [3:0] hour_l_o,
    output logic [2:0] minute_h_o,
    output logic [3:0] minute_l_o,
    output logic [2:0] second_h_o,
    output logic [3:0] second_l_o,
    output logic [1:0] state_o,
    output logic       synced_o,
    output logic       frame_accept_o,
    output logic       frame_reject_o
);

    typedef enum logic [1:0] {
        ST_UNSYNCED  = 2'd0,
        ST_CANDIDATE = 2'd1,
        ST_SYNCED    = 2'd2,
        ST_HOLDOVER  = 2'd3
    } state_t;

    localparam logic [7:0] HOLD_LIMIT = 8'(HOLDOVER_MINUTES);

    state_t     state;
    logic [7:0] hold_cnt;
    logic       mismatch;

    // Running hh:mm advanced by one minute; shared by the tick carry and the expected-minute check.
    logic [1:0] nxm_hour_h;
    logic [3:0] nxm_hour_l;
    logic [2:0] nxm_min_h;
    logic [3:0] nxm_min_l;

    always_comb begin
        nxm_hour_h = hour_h_o;
        nxm_hour_l = hour_l_o;
        nxm_min_h  = minute_h_o;
        nxm_min_l  = minute_l_o;
        if (minute_l_o != 4'd9) begin
            nxm_min_l = minute_l_o + 4'd1;
        end else begin
            nxm_min_l = 4'd0;
            if (minute_h_o != 3'd5) begin
                nxm_min_h = minute_h_o + 3'd1;
            end else begin
                nxm_min_h = 3'd0;
                if (hour_h_o == 2'd2 && hour_l_o == 4'd3) begin
                    nxm_hour_h = 2'd0;
                    nxm_hour_l = 4'd0;
                end else if (hour_l_o == 4'd9) begin
                    nxm_hour_h = hour_h_o + 2'd1;
                    nxm_hour_l = 4'd0;
                end else begin
                    nxm_hour_l = hour_l_o + 4'd1;
                end
            end
        end
    end

    logic [12:0] frame_hm;
    logic        range_ok;
    logic        match;
    logic        load;
    logic        sec_carry;
    logic [7:0]  hold_next;

    assign frame_hm  = {frame_hour_h_i, frame_hour_l_i, frame_minute_h_i, frame_minute_l_i};
    assign range_ok  = (frame_hour_l_i <= 4'd9) && (frame_minute_l_i <= 4'd9) &&
                       (frame_minute_h_i <= 3'd5) &&
                       ((frame_hour_h_i < 2'd2) || (frame_hour_h_i == 2'd2 && frame_hour_l_i <= 4'd3));
    // A frame arriving in the second half of the minute is compared against the minute about to start.
    assign match     = (second_h_o >= 3'd3) ?
                       (frame_hm == {nxm_hour_h, nxm_hour_l, nxm_min_h, nxm_min_l}) :
                       (frame_hm == {hour_h_o, hour_l_o, minute_h_o, minute_l_o});
    assign load      = frame_valid_i && range_ok &&
                       (state == ST_UNSYNCED || state == ST_CANDIDATE || match || mismatch);
    assign sec_carry = (second_h_o == 3'd5) && (second_l_o == 4'd9);
    assign hold_next = (hold_cnt == 8'hFF) ? hold_cnt : hold_cnt + 8'd1;
    assign state_o   = state;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hour_h_o       <= '0;
            hour_l_o       <= '0;
            minute_h_o     <= '0;
            minute_l_o     <= '0;
            second_h_o     <= '0;
            second_l_o     <= '0;
            state          <= ST_UNSYNCED;
            synced_o       <= 1'b0;
            hold_cnt       <= '0;
            mismatch       <= 1'b0;
            frame_accept_o <= 1'b0;
            frame_reject_o <= 1'b0;
        end else begin
            frame_accept_o <= 1'b0;
            frame_reject_o <= 1'b0;

            if (load) begin
                hour_h_o   <= frame_hour_h_i;
                hour_l_o   <= frame_hour_l_i;
                minute_h_o <= frame_minute_h_i;
                minute_l_o <= frame_minute_l_i;
                second_h_o <= 3'd0;
                second_l_o <= 4'd0;
            end else if (tick_1hz_i) begin
                if (second_l_o != 4'd9) begin
                    second_l_o <= second_l_o + 4'd1;
                end else begin
                    second_l_o <= 4'd0;
                    if (second_h_o != 3'd5) begin
                        second_h_o <= second_h_o + 3'd1;
                    end else begin
                        second_h_o <= 3'd0;
                        hour_h_o   <= nxm_hour_h;
                        hour_l_o   <= nxm_hour_l;
                        minute_h_o <= nxm_min_h;
                        minute_l_o <= nxm_min_l;
                    end
                end
                if (sec_carry && state == ST_SYNCED) begin
                    hold_cnt <= hold_next;
                    if (hold_next >= HOLD_LIMIT) begin
                        state    <= ST_HOLDOVER;
                        synced_o <= 1'b0;
                    end
                end
            end

            // Frame decisions come last so a matching frame overrides a same-cycle holdover entry.
            if (frame_valid_i) begin
                if (!range_ok) begin
                    frame_reject_o <= 1'b1;
                end else if (!load) begin
                    frame_reject_o <= 1'b1;
                    mismatch       <= 1'b1;
                end else begin
                    frame_accept_o <= 1'b1;
                    case (state)
                        ST_UNSYNCED: begin
                            state    <= ST_CANDIDATE;
                            synced_o <= 1'b0;
                        end
                        ST_CANDIDATE: begin
                            if (match) begin
                                state    <= ST_SYNCED;
                                synced_o <= 1'b1;
                                hold_cnt <= '0;
                            end
                        end
                        default: begin
                            mismatch <= 1'b0;
                            if (match) begin
                                state    <= ST_SYNCED;
                                synced_o <= 1'b1;
                                hold_cnt <= '0;
                            end else begin
                                state    <= ST_CANDIDATE;
                                synced_o <= 1'b0;
                            end
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_msf_timekeeper.sv
// Self-checking bench for msf_timekeeper: directed scenarios plus a randomized run against a seconds-of-day model.
module tb_msf_timekeeper;

    localparam int HOLD = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       fv = 1'b0;
    logic [1:0] fhh = '0;
    logic [3:0] fhl = '0;
    logic [2:0] fmh = '0;
    logic [3:0] fml = '0;
    logic [1:0] hour_h;
    logic [3:0] hour_l;
    logic [2:0] minute_h;
    logic [3:0] minute_l;
    logic [2:0] second_h;
    logic [3:0] second_l;
    logic [1:0] state;
    logic       synced;
    logic       acc;
    logic       rej;

    int checks = 0;
    int errors = 0;

    // Reference model: time as seconds since midnight, state as 0..3.
    int m_t, m_st, m_cnt;
    bit m_flag, m_acc, m_rej;

    always #5 clk = ~clk;

    msf_timekeeper #(.HOLDOVER_MINUTES(HOLD)) dut (
        .clk_i(clk), .rst_i(rst), .tick_1hz_i(tick), .frame_valid_i(fv),
        .frame_hour_h_i(fhh), .frame_hour_l_i(fhl),
        .frame_minute_h_i(fmh), .frame_minute_l_i(fml),
        .hour_h_o(hour_h), .hour_l_o(hour_l),
        .minute_h_o(minute_h), .minute_l_o(minute_l),
        .second_h_o(second_h), .second_l_o(second_l),
        .state_o(state), .synced_o(synced),
        .frame_accept_o(acc), .frame_reject_o(rej)
    );

    function automatic int dut_t();
        return (int'(hour_h) * 10 + int'(hour_l)) * 3600 +
               (int'(minute_h) * 10 + int'(minute_l)) * 60 +
               int'(second_h) * 10 + int'(second_l);
    endfunction

    function automatic int model_exp_min();
        return (m_t / 60 + ((m_t % 60) >= 30 ? 1 : 0)) % 1440;
    endfunction

    task automatic model_reset();
        m_t = 0; m_st = 0; m_cnt = 0; m_flag = 0; m_acc = 0; m_rej = 0;
    endtask

    task automatic model_step(input bit tk, input bit v, input int hh, input int hl, input int mh, input int ml);
        int f;
        bit in_range, is_match, do_load;
        m_acc = 0; m_rej = 0; do_load = 0; is_match = 0;
        f = (hh * 10 + hl) * 60 + mh * 10 + ml;
        if (v) begin
            in_range = (hl <= 9) && (ml <= 9) && (hh * 10 + hl <= 23) && (mh * 10 + ml <= 59);
            is_match = (f == model_exp_min());
            if (!in_range) m_rej = 1;
            else if (m_st <= 1 || is_match || m_flag) do_load = 1;
            else begin m_rej = 1; m_flag = 1; end
        end
        if (do_load) begin
            m_acc = 1;
            m_t = f * 60;
            if (m_st == 0) m_st = 1;
            else if (m_st == 1) begin
                if (is_match) begin m_st = 2; m_cnt = 0; end
            end else begin
                m_flag = 0;
                if (is_match) begin m_st = 2; m_cnt = 0; end
                else m_st = 1;
            end
        end else if (tk) begin
            if (m_t % 60 == 59 && m_st == 2) begin
                m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
                if (m_cnt >= HOLD) m_st = 3;
            end
            m_t = (m_t + 1) % 86400;
        end
    endtask

    task automatic drive(input bit tk, input bit v, input int hh, input int hl, input int mh, input int ml);
        tick = tk; fv = v;
        fhh = 2'(hh); fhl = 4'(hl); fmh = 3'(mh); fml = 4'(ml);
        model_step(tk, v, hh, hl, mh, ml);
        @(posedge clk); #1;
        tick = 0; fv = 0;
    endtask

    task automatic test_reset();
        int pulses;
        @(posedge clk); #1;
        checks++; if (dut_t() !== 0) begin errors++; $display("FAIL reset_time: got %0d want 0", dut_t()); end
        checks++; if (state !== 2'd0 || synced !== 1'b0) begin errors++; $display("FAIL reset_state: got %0d/%0b want 0/0", state, synced); end
        checks++; if (acc !== 1'b0 || rej !== 1'b0) begin errors++; $display("FAIL reset_pulses: got %0b%0b want 00", acc, rej); end
        tick = 1; fv = 1; fhh = 2'd1; fhl = 4'd2; fmh = 3'd3; fml = 4'd4;
        @(posedge clk); #1;
        tick = 0; fv = 0;
        checks++; if (dut_t() !== 0 || acc !== 1'b0) begin errors++; $display("FAIL reset_ignores_inputs: got t=%0d acc=%0b want 0/0", dut_t(), acc); end
        rst = 0;
        model_reset();
        repeat (5) drive(1, 0, 0, 0, 0, 0);
        #2 rst = 1;
        #1;
        checks++; if (dut_t() !== 0) begin errors++; $display("FAIL async_reset: got %0d want 0", dut_t()); end
        @(negedge clk); rst = 0;
        model_reset();
        pulses = 0;
        for (int i = 0; i < 61; i++) begin
            drive(1, 0, 0, 0, 0, 0);
            if (acc || rej) pulses++;
        end
        checks++; if (dut_t() !== 61) begin errors++; $display("FAIL ticks_61: got %0d want 61", dut_t()); end
        checks++; if (state !== 2'd0 || pulses !== 0) begin errors++; $display("FAIL ticks_61_state: got st=%0d pulses=%0d want 0/0", state, pulses); end
        drive(0, 1, 2, 5, 0, 0);
        checks++; if (rej !== 1'b1 || acc !== 1'b0 || dut_t() !== 61 || state !== 2'd0) begin
            errors++; $display("FAIL range_unsynced: got rej=%0b acc=%0b t=%0d st=%0d want 1/0/61/0", rej, acc, dut_t(), state);
        end
    endtask

    task automatic test_sync_sequence();
        drive(0, 1, 1, 2, 3, 4);
        checks++; if (acc !== 1'b1 || rej !== 1'b0) begin errors++; $display("FAIL cand_accept: got acc=%0b rej=%0b want 1/0", acc, rej); end
        checks++; if (dut_t() !== 12 * 3600 + 34 * 60 || state !== 2'd1) begin
            errors++; $display("FAIL cand_load: got t=%0d st=%0d want %0d/1", dut_t(), state, 12 * 3600 + 34 * 60);
        end
        repeat (60) drive(1, 0, 0, 0, 0, 0);
        drive(0, 1, 1, 2, 3, 5);
        checks++; if (acc !== 1'b1 || state !== 2'd2 || synced !== 1'b1) begin
            errors++; $display("FAIL sync_confirm: got acc=%0b st=%0d synced=%0b want 1/2/1", acc, state, synced);
        end
    endtask

    task automatic test_mismatch();
        drive(0, 1, 0, 7, 0, 0);
        checks++; if (rej !== 1'b1 || acc !== 1'b0 || dut_t() !== 12 * 3600 + 35 * 60 || state !== 2'd2) begin
            errors++; $display("FAIL first_mismatch: got rej=%0b acc=%0b t=%0d st=%0d want 1/0/%0d/2", rej, acc, dut_t(), state, 12 * 3600 + 35 * 60);
        end
        drive(0, 1, 0, 7, 0, 1);
        checks++; if (acc !== 1'b1 || dut_t() !== 7 * 3600 + 60 || state !== 2'd1) begin
            errors++; $display("FAIL second_mismatch: got acc=%0b t=%0d st=%0d want 1/%0d/1", acc, dut_t(), state, 7 * 3600 + 60);
        end
    endtask

    task automatic test_range();
        drive(0, 1, 2, 5, 0, 0);
        checks++; if (rej !== 1'b1 || acc !== 1'b0 || state !== 2'd1 || dut_t() !== 7 * 3600 + 60) begin
            errors++; $display("FAIL range_cand_hour: got rej=%0b st=%0d t=%0d want 1/1/%0d", rej, state, dut_t(), 7 * 3600 + 60);
        end
        drive(0, 1, 1, 2, 3, 10);
        checks++; if (rej !== 1'b1 || state !== 2'd1 || dut_t() !== 7 * 3600 + 60) begin
            errors++; $display("FAIL range_cand_minute: got rej=%0b st=%0d t=%0d want 1/1/%0d", rej, state, dut_t(), 7 * 3600 + 60);
        end
        drive(0, 1, 0, 7, 0, 1);
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL resync: got st=%0d want 2", state); end
        drive(1, 1, 1, 2, 3, 10);
        checks++; if (rej !== 1'b1 || state !== 2'd2 || dut_t() !== 7 * 3600 + 61) begin
            errors++; $display("FAIL range_synced_tick: got rej=%0b st=%0d t=%0d want 1/2/%0d", rej, state, dut_t(), 7 * 3600 + 61);
        end
        drive(0, 1, 0, 7, 0, 1);
    endtask

    task automatic test_holdover();
        repeat (179) drive(1, 0, 0, 0, 0, 0);
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL holdover_early: got st=%0d want 2", state); end
        drive(1, 0, 0, 0, 0, 0);
        checks++; if (state !== 2'd3 || synced !== 1'b0) begin
            errors++; $display("FAIL holdover_enter: got st=%0d synced=%0b want 3/0", state, synced);
        end
        drive(0, 1, 2, 5, 0, 0);
        checks++; if (rej !== 1'b1 || state !== 2'd3) begin errors++; $display("FAIL range_holdover: got rej=%0b st=%0d want 1/3", rej, state); end
        drive(0, 1, 0, 7, 0, 4);
        checks++; if (acc !== 1'b1 || state !== 2'd2 || synced !== 1'b1) begin
            errors++; $display("FAIL holdover_recover: got acc=%0b st=%0d synced=%0b want 1/2/1", acc, state, synced);
        end
    endtask

    task automatic test_midnight();
        drive(0, 1, 2, 3, 5, 9);
        checks++; if (rej !== 1'b1) begin errors++; $display("FAIL midnight_setup_reject: got rej=%0b want 1", rej); end
        drive(0, 1, 2, 3, 5, 9);
        repeat (59) drive(1, 0, 0, 0, 0, 0);
        checks++; if (dut_t() !== 86399 || state !== 2'd1) begin errors++; $display("FAIL pre_midnight: got t=%0d st=%0d want 86399/1", dut_t(), state); end
        drive(1, 1, 0, 0, 0, 0);
        checks++; if (acc !== 1'b1 || dut_t() !== 0 || state !== 2'd2) begin
            errors++; $display("FAIL midnight_collision: got acc=%0b t=%0d st=%0d want 1/0/2", acc, dut_t(), state);
        end
    endtask

    task automatic test_random();
        int hh, hl, mh, ml, e, k;
        bit tk, v;
        for (int n = 0; n < 5000; n++) begin
            tk = ($urandom_range(0, 3) != 0);
            v = ($urandom_range(0, 39) == 0);
            k = $urandom_range(0, 3);
            if (k <= 1) begin
                e = model_exp_min();
                if ($urandom_range(0, 5) == 0) e = (e + 1439) % 1440;
            end else begin
                e = $urandom_range(0, 1439);
            end
            hh = (e / 60) / 10; hl = (e / 60) % 10; mh = (e % 60) / 10; ml = (e % 60) % 10;
            if (k == 3) begin
                hh = $urandom_range(0, 3); hl = $urandom_range(0, 15);
                mh = $urandom_range(0, 7); ml = $urandom_range(0, 15);
            end
            drive(tk, v, hh, hl, mh, ml);
            checks++; if (dut_t() !== m_t) begin errors++; $display("FAIL rand_time @%0d: got %0d want %0d", n, dut_t(), m_t); end
            checks++; if (int'(state) !== m_st) begin errors++; $display("FAIL rand_state @%0d: got %0d want %0d", n, state, m_st); end
            checks++; if (synced !== (m_st == 2)) begin errors++; $display("FAIL rand_synced @%0d: got %0b want %0b", n, synced, m_st == 2); end
            checks++; if (acc !== m_acc || rej !== m_rej) begin
                errors++; $display("FAIL rand_pulses @%0d: got acc=%0b rej=%0b want %0b/%0b", n, acc, rej, m_acc, m_rej);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_sync_sequence();
        test_mismatch();
        test_range();
        test_holdover();
        test_midnight();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
